// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target engine.
//   i2c_tgt_state_e : byte-level protocol state of the target
//   I2C_ACK/I2C_NACK: SDA level of the acknowledge bit
//   RW_READ         : value of the R/W bit for a read transfer
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK
    } i2c_tgt_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes the raw SCL/SDA pad levels into clk_i and
// derives one-cycle bus event pulses.
//   clk_i, rstn_i : system clock, async active-low reset
//   i_scl, i_sda  : raw line levels
//   o_sda         : synchronized SDA level
//   o_scl_rise/o_scl_fall : one-cycle SCL edge pulses
//   o_start/o_stop        : START (SDA fall, SCL high) / STOP (SDA rise, SCL high)
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to the idle bus level so releasing reset on an idle bus
    // produces no spurious edges.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) with a byte-wide register access port.
// First written byte loads the register pointer, further written bytes are
// stored at the pointer, reads return data from the pointer; the pointer
// advances after every data byte. SCL is never stretched.
//   clk_i, rstn_i            : system clock (>= 16x SCL), async active-low reset
//   scl_pad_*, sda_pad_*     : open-drain pad interface (oen low = pull low)
//   reg_addr_o               : register pointer
//   wr_en_o, wr_data_o       : one-cycle write strobe and byte
//   rd_en_o, rd_data_i       : one-cycle read request, data sampled next cycle
//   busy_o                   : addressed transfer in progress (until STOP)
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR    = 7'h50,
    parameter int         REG_ADDR_WIDTH = 8,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      scl_pad_i,
    output logic                      scl_pad_o,
    output logic                      scl_padoen_o,
    input  logic                      sda_pad_i,
    output logic                      sda_pad_o,
    output logic                      sda_padoen_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic                      wr_en_o,
    output logic [7:0]                wr_data_o,
    output logic                      rd_en_o,
    input  logic [7:0]                rd_data_i,
    output logic                      busy_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .i_scl      (scl_pad_i),
        .i_sda      (sda_pad_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_tgt_state_e            r_state, w_state_nxt;
    logic [2:0]                r_bitcnt, w_bitcnt_nxt;
    logic [6:0]                r_shreg, w_shreg_nxt;    // bit 7 never needs storing
    logic                      r_rw, w_rw_nxt;
    logic                      r_ack_phase, w_ack_phase_nxt; // ACK already driven
    logic                      r_nack, w_nack_nxt;
    logic                      r_rd_load, w_rd_load_nxt;     // rd_data_i valid now
    logic [REG_ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic                      r_sda_oen, w_sda_oen_nxt;
    logic                      r_wr_en, w_wr_en_nxt;
    logic [7:0]                r_wr_data, w_wr_data_nxt;
    logic                      r_busy, w_busy_nxt;
    logic                      w_rd_en;
    logic [7:0]                w_shift;

    assign w_shift = {r_shreg, w_sda};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_rw        <= 1'b0;
            r_ack_phase <= 1'b0;
            r_nack      <= I2C_NACK;
            r_rd_load   <= 1'b0;
            r_ptr       <= '0;
            r_sda_oen   <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_rw        <= w_rw_nxt;
            r_ack_phase <= w_ack_phase_nxt;
            r_nack      <= w_nack_nxt;
            r_rd_load   <= w_rd_load_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sda_oen   <= w_sda_oen_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bitcnt_nxt    = r_bitcnt;
        w_shreg_nxt     = r_shreg;
        w_rw_nxt        = r_rw;
        w_ack_phase_nxt = r_ack_phase;
        w_nack_nxt      = r_nack;
        w_rd_load_nxt   = 1'b0;
        w_ptr_nxt       = r_ptr;
        w_sda_oen_nxt   = r_sda_oen;
        w_wr_en_nxt     = 1'b0;
        w_wr_data_nxt   = r_wr_data;
        w_busy_nxt      = r_busy;
        w_rd_en         = 1'b0;

        // Pointer advances the cycle after the write strobe.
        if (r_wr_en) w_ptr_nxt = r_ptr + PTR_ONE;

        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_sda_oen_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bitcnt_nxt  = '0;
            w_sda_oen_nxt = 1'b1;
        end else if (r_rd_load) begin
            // Registered read data arrives now; put its MSB on the bus.
            w_shreg_nxt   = rd_data_i[6:0];
            w_sda_oen_nxt = rd_data_i[7];
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_ADDR, ST_PTR, ST_WRITE: begin
                    if (w_rise) begin
                        w_shreg_nxt  = w_shift[6:0];
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_ack_phase_nxt = 1'b0;
                            if (r_state == ST_ADDR) begin
                                if (w_shift[7:1] == DEVICE_ADDR) begin
                                    w_state_nxt = ST_ADDR_ACK;
                                    w_rw_nxt    = w_shift[0];
                                    w_busy_nxt  = 1'b1;
                                end else begin
                                    w_state_nxt = ST_IDLE;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else if (r_state == ST_PTR) begin
                                w_state_nxt = ST_PTR_ACK;
                                w_ptr_nxt   = REG_ADDR_WIDTH'(w_shift);
                            end else begin
                                w_state_nxt   = ST_WRITE_ACK;
                                w_wr_en_nxt   = 1'b1;
                                w_wr_data_nxt = w_shift;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK: begin
                    // First fall starts the ACK bit, second fall ends it.
                    if (w_fall) begin
                        if (!r_ack_phase) begin
                            w_sda_oen_nxt   = I2C_ACK;
                            w_ack_phase_nxt = 1'b1;
                        end else begin
                            w_bitcnt_nxt = '0;
                            if (r_state == ST_ADDR_ACK && r_rw == RW_READ) begin
                                w_rd_en       = 1'b1;
                                w_rd_load_nxt = 1'b1;
                                w_state_nxt   = ST_READ;
                            end else begin
                                w_sda_oen_nxt = 1'b1;
                                w_state_nxt   = (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WRITE;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (w_fall) begin
                        if (r_bitcnt == 3'd7) begin
                            w_sda_oen_nxt = 1'b1;
                            w_state_nxt   = ST_READ_ACK;
                            w_ptr_nxt     = r_ptr + PTR_ONE;
                        end else begin
                            w_sda_oen_nxt = r_shreg[6];
                            w_shreg_nxt   = {r_shreg[5:0], 1'b0};
                            w_bitcnt_nxt  = r_bitcnt + 3'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (w_rise) w_nack_nxt = w_sda;
                    if (w_fall) begin
                        if (r_nack == I2C_ACK) begin
                            w_rd_en       = 1'b1;
                            w_rd_load_nxt = 1'b1;
                            w_bitcnt_nxt  = '0;
                            w_state_nxt   = ST_READ;
                        end else begin
                            // Master is done; busy holds until STOP.
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = r_sda_oen;
    assign reg_addr_o   = r_ptr;
    assign wr_en_o      = r_wr_en;
    assign wr_data_o    = r_wr_data;
    assign rd_en_o      = w_rd_en;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target. A bit-banged master drives
// SCL/SDA through an open-drain resolution; a registered register file
// answers read requests. Each scenario runs at 16x and 100x clk/SCL.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda;
    logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic       wr_en, rd_en, busy;

    int         tests = 0;
    int         fails = 0;
    int         q = 4;
    int         ratio = 16;
    logic [7:0] mem [256];
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    bit          busy_seen;
    int          both_cnt = 0;

    assign sda = (sda_padoen_o | sda_pad_o) & m_sda;

    always #5 clk = ~clk;

    i2c_target #(.DEVICE_ADDR(7'h50), .REG_ADDR_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .scl_pad_i    (m_scl),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_i    (sda),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .reg_addr_o   (reg_addr),
        .wr_en_o      (wr_en),
        .wr_data_o    (wr_data),
        .rd_en_o      (rd_en),
        .rd_data_i    (rd_data),
        .busy_o       (busy)
    );

    // Registered register-file read.
    always @(posedge clk) if (rd_en) rd_data <= mem[reg_addr];

    always @(negedge clk) begin
        if (rstn) begin
            if (wr_en) wq.push_back({reg_addr, wr_data});
            if (rd_en) rq.push_back(reg_addr);
            if (wr_en && rd_en) both_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        wq.delete();
        rq.delete();
        busy_seen = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; waitc(q);
        m_sda = 1'b0; waitc(q);
        m_scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        waitc(q); m_sda = 1'b1;
        waitc(q); m_scl = 1'b1;
        waitc(q); m_sda = 1'b0;
        waitc(q); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        waitc(q); m_sda = 1'b0;
        waitc(q); m_scl = 1'b1;
        waitc(q); m_sda = 1'b1;
        waitc(2 * q);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        waitc(q); m_sda = b;
        waitc(q); m_scl = 1'b1;
        waitc(q); r = sda;
        waitc(q); m_scl = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(nack, r);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        waitc(2);
        tests++;
        if ({sda_padoen_o, scl_padoen_o, sda_pad_o, scl_pad_o, wr_en, rd_en, busy} !== 7'b1100000) begin
            fails++;
            $display("FAIL reset_ctrl r%0d: got %b exp 1100000", ratio,
                     {sda_padoen_o, scl_padoen_o, sda_pad_o, scl_pad_o, wr_en, rd_en, busy});
        end
        tests++;
        if ({reg_addr, wr_data} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data r%0d: got %h exp 0000", ratio, {reg_addr, wr_data});
        end
        rstn = 1'b1;
        waitc(4);
    endtask

    task automatic test_write();
        logic [3:0]  a;
        logic [15:0] g;
        clr();
        i2c_start();
        wbyte(8'hA0, a[0]);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL wr_busy r%0d: got %b exp 1", ratio, busy);
        end
        wbyte(8'h10, a[1]);
        wbyte(8'h5A, a[2]);
        wbyte(8'hC3, a[3]);
        i2c_stop();
        tests++;
        if (a !== 4'b0000) begin
            fails++;
            $display("FAIL wr_acks r%0d: got %b exp 0000", ratio, a);
        end
        tests++;
        if (wq.size() != 2) begin
            fails++;
            $display("FAIL wr_count r%0d: got %0d exp 2", ratio, wq.size());
        end
        g = (wq.size() > 0) ? wq[0] : 16'hxxxx;
        tests++;
        if (g !== 16'h105A) begin
            fails++;
            $display("FAIL wr_first r%0d: got %h exp 105a", ratio, g);
        end
        g = (wq.size() > 1) ? wq[1] : 16'hxxxx;
        tests++;
        if (g !== 16'h11C3) begin
            fails++;
            $display("FAIL wr_second r%0d: got %h exp 11c3", ratio, g);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL wr_busy_stop r%0d: got %b exp 0", ratio, busy);
        end
    endtask

    task automatic test_read();
        logic [2:0] a;
        logic [7:0] d0, d1, g;
        mem[8'h20] = 8'h96;
        mem[8'h21] = 8'h3C;
        clr();
        i2c_start();
        wbyte(8'hA0, a[0]);
        wbyte(8'h20, a[1]);
        i2c_rstart();
        wbyte(8'hA1, a[2]);
        rbyte(1'b0, d0);
        rbyte(1'b1, d1);
        waitc(q);
        tests++;
        if (sda_padoen_o !== 1'b1) begin
            fails++;
            $display("FAIL rd_release r%0d: got %b exp 1", ratio, sda_padoen_o);
        end
        i2c_stop();
        tests++;
        if (a !== 3'b000) begin
            fails++;
            $display("FAIL rd_acks r%0d: got %b exp 000", ratio, a);
        end
        tests++;
        if ({d0, d1} !== 16'h963C) begin
            fails++;
            $display("FAIL rd_data r%0d: got %h exp 963c", ratio, {d0, d1});
        end
        tests++;
        if (rq.size() != 2) begin
            fails++;
            $display("FAIL rd_count r%0d: got %0d exp 2", ratio, rq.size());
        end
        g = (rq.size() > 0) ? rq[0] : 8'hxx;
        tests++;
        if (g !== 8'h20) begin
            fails++;
            $display("FAIL rd_addr0 r%0d: got %h exp 20", ratio, g);
        end
        g = (rq.size() > 1) ? rq[1] : 8'hxx;
        tests++;
        if (g !== 8'h21) begin
            fails++;
            $display("FAIL rd_addr1 r%0d: got %h exp 21", ratio, g);
        end
        tests++;
        if (wq.size() != 0) begin
            fails++;
            $display("FAIL rd_no_write r%0d: got %0d exp 0", ratio, wq.size());
        end
    endtask

    task automatic test_wrong_addr();
        logic [1:0] a;
        clr();
        i2c_start();
        wbyte(8'hA2, a[0]);
        wbyte(8'h00, a[1]);
        i2c_stop();
        tests++;
        if (a !== 2'b11) begin
            fails++;
            $display("FAIL wa_nack r%0d: got %b exp 11", ratio, a);
        end
        tests++;
        if ({busy_seen, 8'(wq.size())} !== 9'd0) begin
            fails++;
            $display("FAIL wa_quiet r%0d: got busy %b writes %0d exp 0/0", ratio, busy_seen, wq.size());
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  a;
        logic [15:0] g;
        clr();
        i2c_start();
        wbyte(8'hA0, a[0]);
        wbyte(8'hFF, a[1]);
        wbyte(8'h11, a[2]);
        wbyte(8'h22, a[3]);
        i2c_stop();
        tests++;
        if (a !== 4'b0000) begin
            fails++;
            $display("FAIL wrap_acks r%0d: got %b exp 0000", ratio, a);
        end
        g = (wq.size() > 0) ? wq[0] : 16'hxxxx;
        tests++;
        if (g !== 16'hFF11) begin
            fails++;
            $display("FAIL wrap_first r%0d: got %h exp ff11", ratio, g);
        end
        g = (wq.size() > 1) ? wq[1] : 16'hxxxx;
        tests++;
        if (g !== 16'h0022) begin
            fails++;
            $display("FAIL wrap_second r%0d: got %h exp 0022", ratio, g);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] a;
        logic       r, ack;
        mem[8'h40] = 8'h00;
        clr();
        i2c_start();
        wbyte(8'hA0, a[0]);
        wbyte(8'h40, a[1]);
        i2c_rstart();
        wbyte(8'hA1, a[2]);
        clk_bit(1'b1, r);
        clk_bit(1'b1, r);
        waitc(2 * q);
        tests++;
        if (sda_padoen_o !== 1'b0) begin
            fails++;
            $display("FAIL rm_driving r%0d: got %b exp 0", ratio, sda_padoen_o);
        end
        rstn = 1'b0;
        #1;
        tests++;
        if ({sda_padoen_o, busy} !== 2'b10) begin
            fails++;
            $display("FAIL rm_release r%0d: got %b exp 10", ratio, {sda_padoen_o, busy});
        end
        m_sda = 1'b1;
        m_scl = 1'b1;
        waitc(2);
        rstn = 1'b1;
        waitc(4 * q);
        i2c_start();
        wbyte(8'hA0, ack);
        i2c_stop();
        tests++;
        if (ack !== 1'b0) begin
            fails++;
            $display("FAIL rm_reack r%0d: got %b exp 0", ratio, ack);
        end
    endtask

    task automatic test_no_collision();
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL rd_wr_overlap r%0d: got %0d exp 0", ratio, both_cnt);
        end
    endtask

    initial begin
        int ratios [2];
        ratios = '{16, 100};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rd_data = 8'h00;
        foreach (ratios[k]) begin
            ratio = ratios[k];
            q = ratio / 4;
            test_reset();
            test_write();
            test_read();
            test_wrong_addr();
            test_wrap();
            test_reset_mid_read();
            test_no_collision();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
